// File: rtl/score_tracker_pkg.sv
// score_tracker_pkg: shared definitions for the score tracker.
//   - state_e     : game FSM encoding (IDLE/PLAY/WON; 2'd3 recovers to IDLE)
//   - DEF_*       : default parameter values used by the interface and top
package score_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_MAX_SCORE  = 15;
    localparam int unsigned DEF_STREAK_LEN = 3;
    localparam int unsigned DEF_PENALTY    = 1;

endpackage

// File: rtl/score_tracker_if.sv
// score_tracker_if: bundles the answer pulses and the score/status outputs.
//   master : answer comparator / bench side (drives start, is_equal, is_wrong)
//   slave  : score_tracker side (drives score, high_score, streak, playing,
//            won, new_high)
interface score_tracker_if
    import score_tracker_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned STREAK_LEN = DEF_STREAK_LEN
);
    localparam int unsigned SW = $clog2(STREAK_LEN);

    logic             start;
    logic             is_equal;
    logic             is_wrong;
    logic [WIDTH-1:0] score;
    logic [WIDTH-1:0] high_score;
    logic [SW-1:0]    streak;
    logic             playing;
    logic             won;
    logic             new_high;

    modport master (
        output start, is_equal, is_wrong,
        input  score, high_score, streak, playing, won, new_high
    );

    modport slave (
        input  start, is_equal, is_wrong,
        output score, high_score, streak, playing, won, new_high
    );

endinterface

// File: rtl/score_tracker_streak_counter.sv
// streak_counter: counts consecutive correct answers modulo STREAK_LEN.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear streak (game start/restart)
//   hit        : qualified correct answer
//   miss       : qualified wrong answer (clears streak)
//   streak     : current consecutive-correct count
//   bonus      : combinational, hit lands on the last slot of the streak
module streak_counter #(
    parameter int unsigned STREAK_LEN = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          hit,
    input  logic                          miss,
    output logic [$clog2(STREAK_LEN)-1:0] streak,
    output logic                          bonus
);
    localparam int unsigned SW = $clog2(STREAK_LEN);

    logic [SW-1:0] streak_q, streak_d;

    assign bonus = hit && (streak_q == SW'(STREAK_LEN - 1));

    always_comb begin
        streak_d = streak_q;
        if (clr || miss) begin
            streak_d = '0;
        end else if (hit) begin
            streak_d = bonus ? '0 : streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak = streak_q;

endmodule

// File: rtl/score_tracker.sv
// score_tracker: game score engine with streak bonus, wrong-answer penalty,
// saturation at MAX_SCORE (entering WON) and a persistent high score.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : score_tracker_if slave modport
//                in : start, is_equal, is_wrong (one-cycle pulses)
//                out: score, high_score, streak, playing, won, new_high
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned MAX_SCORE  = DEF_MAX_SCORE,
    parameter int unsigned STREAK_LEN = DEF_STREAK_LEN,
    parameter int unsigned PENALTY    = DEF_PENALTY
) (
    input  logic            clk,
    input  logic            rst_n,
    score_tracker_if.slave  bus
);
    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_SCORE);
    localparam logic [WIDTH:0] PEN_W = (WIDTH+1)'(PENALTY);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] score_q, score_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             new_high_q, new_high_d;

    logic             in_play;
    logic             hit, miss, bonus;
    logic [WIDTH:0]   score_ext, incr, sum;

    // Answer qualification kept outside the main comb block so the streak
    // counter's bonus output does not feed back into its own inputs.
    // start wins over answers; a simultaneous correct+wrong counts as wrong.
    assign in_play = (state_q == ST_PLAY);
    assign hit     = in_play && !bus.start && bus.is_equal && !bus.is_wrong;
    assign miss    = in_play && !bus.start && bus.is_wrong;

    streak_counter #(
        .STREAK_LEN (STREAK_LEN)
    ) u_streak (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.start),
        .hit    (hit),
        .miss   (miss),
        .streak (bus.streak),
        .bonus  (bonus)
    );

    assign score_ext = {1'b0, score_q};
    assign incr      = bonus ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
    assign sum       = score_ext + incr;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                if (bus.start) begin
                    score_d = '0;
                end else if (miss) begin
                    score_d = (score_ext < PEN_W) ? '0 : WIDTH'(score_ext - PEN_W);
                end else if (hit) begin
                    score_d = (sum >= MAX_W) ? WIDTH'(MAX_SCORE) : sum[WIDTH-1:0];
                end
                if ({1'b0, score_d} >= MAX_W) begin
                    score_d = WIDTH'(MAX_SCORE);
                    state_d = ST_WON;
                end
            end
            ST_WON: begin
                if (bus.start) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                score_d = '0;
            end
        endcase

        if (score_d > high_q) begin
            high_d     = score_d;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.new_high   = new_high_q;
    assign bus.playing    = (state_q == ST_PLAY);
    assign bus.won        = (state_q == ST_WON);

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed self-checking bench for score_tracker with
// default parameters (WIDTH=4, MAX_SCORE=15, STREAK_LEN=3, PENALTY=1).
module tb_score_tracker;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    score_tracker_if #(.WIDTH(4), .STREAK_LEN(3)) bus ();

    score_tracker #(
        .WIDTH      (4),
        .MAX_SCORE  (15),
        .STREAK_LEN (3),
        .PENALTY    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full output snapshot: score, high_score, streak, playing, won, new_high
    task automatic expect_all(input string tag, input int sc, input int hs,
                              input int st, input int pl, input int wn,
                              input int nh);
        check({tag, ".score"},      int'(bus.score),      sc);
        check({tag, ".high_score"}, int'(bus.high_score), hs);
        check({tag, ".streak"},     int'(bus.streak),     st);
        check({tag, ".playing"},    int'(bus.playing),    pl);
        check({tag, ".won"},        int'(bus.won),        wn);
        check({tag, ".new_high"},   int'(bus.new_high),   nh);
    endtask

    // Drive one cycle of pulses at the falling edge, sample 1ns after rising
    task automatic step(input logic s, input logic e, input logic w);
        @(negedge clk);
        bus.start    = s;
        bus.is_equal = e;
        bus.is_wrong = w;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.is_equal = 1'b0;
        bus.is_wrong = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.is_equal = 1'b0;
        bus.is_wrong = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Answers ignored in IDLE
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        expect_all("idle_ignore", 0, 0, 0, 0, 0, 0);

        step(1, 0, 0);
        expect_all("start", 0, 0, 0, 1, 0, 0);

        // Penalty floors at zero
        step(0, 0, 1);
        expect_all("wrong_at_0", 0, 0, 0, 1, 0, 0);

        // Streak: 1, 2, then bonus to 4
        step(0, 1, 0); expect_all("hit1", 1, 1, 1, 1, 0, 1);
        step(0, 1, 0); expect_all("hit2", 2, 2, 2, 1, 0, 1);
        step(0, 1, 0); expect_all("hit3_bonus", 4, 4, 0, 1, 0, 1);

        // Simultaneous correct+wrong counts as wrong
        step(0, 1, 1); expect_all("both", 3, 4, 0, 1, 0, 0);

        // Back to 4 (ties high score, no pulse), then 5 beats it
        step(0, 1, 0); expect_all("tie_high", 4, 4, 1, 1, 0, 0);
        step(0, 1, 0); expect_all("new_high5", 5, 5, 2, 1, 0, 1);
        step(0, 0, 0); expect_all("new_high_drop", 5, 5, 2, 1, 0, 0);

        // Restart keeps high score; next game below it gives no pulse
        step(1, 0, 0); expect_all("restart", 0, 5, 0, 1, 0, 0);
        step(0, 1, 0); expect_all("g2_1", 1, 5, 1, 1, 0, 0);
        step(0, 1, 0); expect_all("g2_2", 2, 5, 2, 1, 0, 0);
        step(0, 1, 0); expect_all("g2_4", 4, 5, 0, 1, 0, 0);
        step(0, 1, 0); expect_all("g2_5", 5, 5, 1, 1, 0, 0);
        step(0, 1, 0); expect_all("g2_6", 6, 6, 2, 1, 0, 1);
        step(0, 1, 0); expect_all("g2_8", 8, 8, 0, 1, 0, 1);
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        expect_all("g2_12", 12, 12, 0, 1, 0, 1);
        step(0, 1, 0); expect_all("g2_13", 13, 13, 1, 1, 0, 1);
        step(0, 1, 0); expect_all("g2_14", 14, 14, 2, 1, 0, 1);

        // 14 + bonus 2 saturates at 15 and wins
        step(0, 1, 0); expect_all("win_sat", 15, 15, 0, 0, 1, 1);
        step(0, 1, 0); expect_all("won_frozen", 15, 15, 0, 0, 1, 0);
        step(0, 0, 1); expect_all("won_wrong", 15, 15, 0, 0, 1, 0);

        // Restart from WON, climb to 7, then start beats a correct answer
        step(1, 0, 0); expect_all("won_restart", 0, 15, 0, 1, 0, 0);
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        expect_all("g3_4", 4, 15, 0, 1, 0, 0);
        step(0, 1, 0); step(0, 1, 0);
        expect_all("g3_6", 6, 15, 2, 1, 0, 0);
        step(0, 0, 1); expect_all("g3_5", 5, 15, 0, 1, 0, 0);
        step(0, 1, 0); step(0, 1, 0);
        expect_all("g3_7", 7, 15, 2, 1, 0, 0);
        step(1, 1, 0); expect_all("start_prio", 0, 15, 0, 1, 0, 0);

        // Asynchronous reset mid-game, between edges
        step(0, 1, 0); step(0, 1, 0);
        expect_all("pre_reset", 2, 15, 2, 1, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_all("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0);
        expect_all("post_reset_idle", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
